// File: rtl/seg4x7_pkg.sv
// Shared types and ASCII helpers for the 4-digit 7-segment scroller.
package seg4x7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STATIC = 2'd2,
        SCROLL = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

endpackage

// File: rtl/seg4x7_step_timer.sv
// Free-running scroll-step divider: tick is high for one cycle every STEP_DIV enabled cycles.
module seg4x7_step_timer #(
    parameter int STEP_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CW'(STEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg4x7_scroller.sv
// Buffers one ASCII line and presents it as four characters: right-aligned when short,
// continuously scrolling with a four-space gap when longer than four characters.
module seg4x7_scroller
    import seg4x7_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int STEP_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clear,
    output logic [31:0] text_out,
    output logic        scrolling,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    state_e        state_q;
    logic [PW-1:0] len_q, pos_q;
    logic          ready_q, scrolling_q, overflow_q;
    logic [31:0]   text_q, text_d;

    logic          xfer, is_lf, is_cr, storable, tick;
    logic [7:0]    ch;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] scroll_len, v;

    assign char_ready = ready_q & ~rst & ~clear;
    assign xfer       = char_valid & char_ready;
    assign is_lf      = (char_data == ASCII_LF);
    assign is_cr      = (char_data == ASCII_CR);
    assign storable   = xfer & ~is_lf & ~is_cr;
    assign ch         = to_upper(char_data);
    assign scroll_len = len_q + PW'(4);

    seg4x7_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (clear | (state_q != SCROLL)),
        .en      (state_q == SCROLL),
        .tick    (tick)
    );

    // Outside LOAD a storable character always restarts the message at slot 0.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (storable) begin
            if (state_q != LOAD) begin
                wr_en = 1'b1;
            end else if (len_q < PW'(DEPTH)) begin
                wr_en   = 1'b1;
                wr_addr = len_q[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pos_q       <= '0;
            ready_q     <= 1'b0;
            scrolling_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (clear) begin
                state_q     <= IDLE;
                len_q       <= '0;
                pos_q       <= '0;
                scrolling_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else if (storable && state_q != LOAD) begin
                state_q     <= LOAD;
                len_q       <= PW'(1);
                scrolling_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else if (xfer && !is_cr && state_q == LOAD) begin
                if (is_lf) begin
                    if (len_q > PW'(4)) begin
                        state_q     <= SCROLL;
                        scrolling_q <= 1'b1;
                        pos_q       <= '0;
                    end else begin
                        state_q <= STATIC;
                    end
                end else if (len_q < PW'(DEPTH)) begin
                    len_q <= len_q + PW'(1);
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (state_q == SCROLL && tick) begin
                pos_q <= (pos_q == scroll_len - PW'(1)) ? '0 : pos_q + PW'(1);
            end
        end
    end

    // Scrolling walks a virtual line of the message plus four trailing spaces.
    always_comb begin
        text_d = {4{ASCII_SPACE}};
        v      = '0;
        for (int k = 0; k < 4; k++) begin
            if (state_q == SCROLL) begin
                v = pos_q + PW'(k);
                if (v >= scroll_len) v = v - scroll_len;
                if (v < len_q) text_d[31-8*k -: 8] = mem_q[v[AW-1:0]];
            end else begin
                v = len_q + PW'(k);
                if (v >= PW'(4)) begin
                    v = v - PW'(4);
                    text_d[31-8*k -: 8] = mem_q[v[AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            text_q <= {4{ASCII_SPACE}};
        end else begin
            text_q <= text_d;
        end
    end

    assign text_out  = text_q;
    assign scrolling = scrolling_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg4x7_scroller.sv
// Bench for seg4x7_scroller: directed scenarios plus random traffic against a queue-based line model.
module tb_seg4x7_scroller;

    localparam int DEPTH    = 16;
    localparam int STEP_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_data = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        clear = 1'b0;
    logic [31:0] text_out;
    logic        scrolling;
    logic        overflow;

    int n_chk = 0;
    int n_err = 0;

    seg4x7_scroller #(.DEPTH(DEPTH), .STEP_DIV(STEP_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .text_out   (text_out),
        .scrolling  (scrolling),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line model: message kept as a byte queue, scroll position derived from elapsed cycles.
    logic [7:0]  m_msg[$];
    int          m_mode = 0;        // 0 idle, 1 loading, 2 static, 3 scrolling
    int          m_sc = 0;          // edges spent in scrolling mode
    logic        m_ovf = 1'b0;
    logic        m_rdy = 1'b0;
    logic [31:0] m_text = 32'h20202020;
    logic        m_init = 1'b0;

    function automatic logic [31:0] m_disp();
        logic [31:0] r;
        logic [7:0]  c;
        int n, L, p, idx;
        r = 32'h20202020;
        n = m_msg.size();
        for (int k = 0; k < 4; k++) begin
            c = 8'h20;
            if (m_mode == 3) begin
                L   = n + 4;
                p   = (m_sc / STEP_DIV) % L;
                idx = (p + k) % L;
                if (idx < n) c = m_msg[idx];
            end else begin
                idx = n - 4 + k;
                if (idx >= 0) c = m_msg[idx];
            end
            r[31-8*k -: 8] = c;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [31:0] nt;
        logic [7:0]  c;
        logic        xf;
        int          prev;
        nt   = m_disp();
        xf   = char_valid && m_rdy && !rst && !clear;
        prev = m_mode;
        if (rst) begin
            m_mode = 0; m_msg.delete(); m_ovf = 1'b0; m_rdy = 1'b0; m_sc = 0;
            nt = 32'h20202020;
        end else begin
            m_rdy = 1'b1;
            if (clear) begin
                m_mode = 0; m_msg.delete(); m_ovf = 1'b0; m_sc = 0;
                nt = 32'h20202020;
            end else if (xf && char_data != 8'h0D) begin
                if (char_data == 8'h0A) begin
                    if (m_mode == 1) begin
                        m_mode = (m_msg.size() > 4) ? 3 : 2;
                        m_sc   = 0;
                    end
                end else begin
                    c = char_data;
                    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
                    if (m_mode == 1) begin
                        if (m_msg.size() < DEPTH) m_msg.push_back(c);
                        else m_ovf = 1'b1;
                    end else begin
                        m_msg.delete();
                        m_msg.push_back(c);
                        m_mode = 1;
                        m_ovf  = 1'b0;
                    end
                end
            end
            if (prev == 3 && m_mode == 3) m_sc++;
        end
        m_text = nt;
        m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            check_val("text_out", text_out, m_text);
            check_val("char_ready", {31'b0, char_ready}, {31'b0, m_rdy && !rst && !clear});
            check_val("scrolling", {31'b0, scrolling}, {31'b0, m_mode == 3});
            check_val("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic r);
        char_valid = v;
        char_data  = d;
        clear      = c;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i], 1'b0, 1'b0);
        char_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom % 16;
        case (r)
            0:             return 8'h0A;
            1:             return 8'h0D;
            2, 3, 4, 5, 6: return 8'h61 + 8'($urandom % 26);
            7, 8, 9, 10:   return 8'h41 + 8'($urandom % 26);
            11, 12, 13:    return 8'h30 + 8'($urandom % 10);
            14:            return 8'($urandom);
            default:       return 8'h20;
        endcase
    endfunction

    initial begin
        int n;
        int gap;
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_val("reset_text", text_out, 32'h20202020);
        check_val("reset_ready", {31'b0, char_ready}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("ready_after_rst", {31'b0, char_ready}, 32'd1);

        // "ab" + LF: static, right-aligned, uppercased
        send_str("ab\n");
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("ab_text", text_out, 32'h20204142);
        check_val("ab_scrolling", {31'b0, scrolling}, 32'd0);

        // "HELLO" + LF: scroll through nine positions
        send_str("HELLO\n");
        check_val("hello_scrolling", {31'b0, scrolling}, 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("hello_pos0", text_out, 32'h484C4C4C ^ 32'h00090000);
        repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("hello_pos1", text_out, 32'h454C4C4F);
        repeat (12) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("hello_pos4", text_out, 32'h4F202020);
        repeat (20) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("hello_wrap", text_out, 32'h48454C4C);

        // 17 characters into a 16-deep buffer
        send_str("abcdefghijklmnopq");
        check_val("ovf_set", {31'b0, overflow}, 32'd1);
        check_val("ovf_ready", {31'b0, char_ready}, 32'd1);
        send_str("\n");
        check_val("long_scrolling", {31'b0, scrolling}, 32'd1);
        repeat (30) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // New message during scroll
        send_str("7");
        check_val("new_ovf", {31'b0, overflow}, 32'd0);
        check_val("new_scrolling", {31'b0, scrolling}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("new_text", text_out, 32'h20202037);

        // Clear coincident with a valid character
        char_valid = 1'b1; char_data = 8'h58; clear = 1'b1;
        #1;
        check_val("clear_ready", {31'b0, char_ready}, 32'd0);
        @(posedge clk);
        #1;
        char_valid = 1'b0; clear = 1'b0;
        check_val("clear_text", text_out, 32'h20202020);

        // CR, LF from idle
        char_valid = 1'b1; char_data = 8'h0D;
        #1;
        check_val("cr_ready", {31'b0, char_ready}, 32'd1);
        @(posedge clk);
        #1;
        char_data = 8'h0A;
        #1;
        check_val("lf_ready", {31'b0, char_ready}, 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_val("crlf_text", text_out, 32'h20202020);
        check_val("crlf_scrolling", {31'b0, scrolling}, 32'd0);

        // Random lines, gaps, occasional clear and reset
        for (int m = 0; m < 60; m++) begin
            n = $urandom_range(0, 20);
            for (int j = 0; j < n; j++) begin
                cyc(($urandom % 3) != 0, rand_char(), ($urandom % 300) == 0, ($urandom % 700) == 0);
            end
            cyc(1'b1, 8'h0A, 1'b0, 1'b0);
            gap = $urandom_range(0, 60);
            for (int j = 0; j < gap; j++) cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
